// File: rtl/inst_issue_buffer_pkg.sv
// Shared definitions for the instruction issue buffer.
//   - Buffer geometry (depth, pointer width, full threshold)
//   - Issue-mode encodings used by decode
//   - Entry record stored per instruction: {bpu, addr, inst}
package inst_issue_buffer_pkg;

  localparam int IBUF_DEPTH = 32;
  localparam int IBUF_PTR_W = 5;   // log2(IBUF_DEPTH)
  localparam int INST_W     = 32;
  localparam int BPU_W      = 33;  // {taken, target}

  localparam logic DUAL_ISSUE   = 1'b1;
  localparam logic SINGLE_ISSUE = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Fetch is told to hold once no more than two slots remain free, so a
  // dual push accepted on the last open cycle can never overrun the array.
  localparam logic [IBUF_PTR_W:0] FULL_LEVEL = (IBUF_PTR_W + 1)'(IBUF_DEPTH - 2);

  typedef struct packed {
    logic [BPU_W-1:0]  bpu;
    logic [31:0]       addr;
    logic [INST_W-1:0] inst;
  } ibuf_entry_t;

endpackage

// File: rtl/inst_issue_buffer_if.sv
// Fetch/decode-side bundle of the instruction issue buffer.
//   master : fetch + decode (drives flush, fetch slots, issue handshake;
//            observes head entries, issue_en, full, count)
//   slave  : the buffer itself
interface inst_issue_buffer_if;
  import inst_issue_buffer_pkg::*;

  logic                  flush_i;
  logic                  fetch_valid1_i;
  logic                  fetch_valid2_i;
  logic [INST_W-1:0]     fetch_inst1_i;
  logic [INST_W-1:0]     fetch_inst2_i;
  logic [31:0]           fetch_addr1_i;
  logic [31:0]           fetch_addr2_i;
  logic [BPU_W-1:0]      fetch_bpu1_i;
  logic [BPU_W-1:0]      fetch_bpu2_i;
  logic                  issued_i;
  logic                  issue_mode_i;
  logic                  ninst_in_delayslot_i;

  logic [INST_W-1:0]     inst1_o;
  logic [INST_W-1:0]     inst2_o;
  logic [31:0]           inst1_addr_o;
  logic [31:0]           inst2_addr_o;
  logic [BPU_W-1:0]      bpu1_o;
  logic [BPU_W-1:0]      bpu2_o;
  logic                  issue_en_o;
  logic                  is_in_delayslot_o;
  logic                  buffer_full_o;
  logic [IBUF_PTR_W:0]   count_o;

  modport master (
    output flush_i, fetch_valid1_i, fetch_valid2_i,
           fetch_inst1_i, fetch_inst2_i, fetch_addr1_i, fetch_addr2_i,
           fetch_bpu1_i, fetch_bpu2_i,
           issued_i, issue_mode_i, ninst_in_delayslot_i,
    input  inst1_o, inst2_o, inst1_addr_o, inst2_addr_o, bpu1_o, bpu2_o,
           issue_en_o, is_in_delayslot_o, buffer_full_o, count_o
  );

  modport slave (
    input  flush_i, fetch_valid1_i, fetch_valid2_i,
           fetch_inst1_i, fetch_inst2_i, fetch_addr1_i, fetch_addr2_i,
           fetch_bpu1_i, fetch_bpu2_i,
           issued_i, issue_mode_i, ninst_in_delayslot_i,
    output inst1_o, inst2_o, inst1_addr_o, inst2_addr_o, bpu1_o, bpu2_o,
           issue_en_o, is_in_delayslot_o, buffer_full_o, count_o
  );

endinterface

// File: rtl/inst_issue_buffer_ibuf_ram.sv
// ibuf_ram: 2-write / 2-read register array holding buffer entries.
//   clk            clock
//   we1/waddr1/wdata1  write port 1 (slot1 of fetch)
//   we2/waddr2/wdata2  write port 2 (slot2 of fetch; never aliases port 1)
//   raddr1/rdata1      async read of head
//   raddr2/rdata2      async read of head+1
module ibuf_ram
  import inst_issue_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  we1,
  input  logic [IBUF_PTR_W-1:0] waddr1,
  input  ibuf_entry_t           wdata1,
  input  logic                  we2,
  input  logic [IBUF_PTR_W-1:0] waddr2,
  input  ibuf_entry_t           wdata2,
  input  logic [IBUF_PTR_W-1:0] raddr1,
  output ibuf_entry_t           rdata1,
  input  logic [IBUF_PTR_W-1:0] raddr2,
  output ibuf_entry_t           rdata2
);

  ibuf_entry_t mem [IBUF_DEPTH];

  // NOTE: storage has no reset; validity is tracked by the pointers/count,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we1) mem[waddr1] <= wdata1;
    if (we2) mem[waddr2] <= wdata2;
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/inst_issue_buffer.sv
// inst_issue_buffer: circular instruction buffer between dual fetch and
// dual-issue decode.
//   clk   clock
//   rst   synchronous active-high reset (priority over flush)
//   ibus  fetch slots, issue handshake, flush in; head entries, issue_en,
//         delay-slot flag, full and occupancy out
// Entries become visible one cycle after they are written (no bypass).
module inst_issue_buffer
  import inst_issue_buffer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  inst_issue_buffer_if.slave ibus
);

  logic [IBUF_PTR_W-1:0] head;
  logic [IBUF_PTR_W-1:0] tail;
  logic [IBUF_PTR_W:0]   count;
  logic                  delayslot;

  logic                  full;
  logic                  issue_en;
  logic                  push1;
  logic                  push2;
  logic [1:0]            npush;
  logic [1:0]            npop;
  ibuf_entry_t           wdata1;
  ibuf_entry_t           wdata2;
  ibuf_entry_t           rdata1;
  ibuf_entry_t           rdata2;

  // NOTE: every combinational output gets a default first so no path
  // through the block can leave a variable unassigned (no latch).
  always_comb begin
    full     = (count >= FULL_LEVEL);
    issue_en = (count >= (IBUF_PTR_W + 1)'(2));
    push1    = ibus.fetch_valid1_i & ~full;
    // slot2 is only meaningful behind a valid slot1
    push2    = push1 & ibus.fetch_valid2_i;
    npush    = {1'b0, push1} + {1'b0, push2};
    npop     = 2'd0;
    if (ibus.issued_i && issue_en) begin
      npop = (ibus.issue_mode_i == DUAL_ISSUE) ? 2'd2 : 2'd1;
    end
  end

  assign wdata1 = '{bpu: ibus.fetch_bpu1_i, addr: ibus.fetch_addr1_i, inst: ibus.fetch_inst1_i};
  assign wdata2 = '{bpu: ibus.fetch_bpu2_i, addr: ibus.fetch_addr2_i, inst: ibus.fetch_inst2_i};

  ibuf_ram u_ram (
    .clk    (clk),
    .we1    (push1 & ~ibus.flush_i),
    .waddr1 (tail),
    .wdata1 (wdata1),
    .we2    (push2 & ~ibus.flush_i),
    .waddr2 (tail + IBUF_PTR_W'(1)),
    .wdata2 (wdata2),
    .raddr1 (head),
    .rdata1 (rdata1),
    .raddr2 (head + IBUF_PTR_W'(1)),
    .rdata2 (rdata2)
  );

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      delayslot <= 1'b0;
    end else if (ibus.flush_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      delayslot <= 1'b0;
    end else begin
      head  <= head + IBUF_PTR_W'(npop);
      tail  <= tail + IBUF_PTR_W'(npush);
      count <= count + (IBUF_PTR_W + 1)'(npush) - (IBUF_PTR_W + 1)'(npop);
      // A lone branch leaves its delay slot at the head; a dual pop
      // always takes branch and slot together.
      if (npop != 2'd0) begin
        delayslot <= (ibus.issue_mode_i == SINGLE_ISSUE) ? ibus.ninst_in_delayslot_i : 1'b0;
      end
    end
  end

  always_comb begin
    ibus.inst1_o      = ZERO_WORD;
    ibus.inst1_addr_o = ZERO_WORD;
    ibus.bpu1_o       = '0;
    ibus.inst2_o      = ZERO_WORD;
    ibus.inst2_addr_o = ZERO_WORD;
    ibus.bpu2_o       = '0;
    if (count != '0) begin
      ibus.inst1_o      = rdata1.inst;
      ibus.inst1_addr_o = rdata1.addr;
      ibus.bpu1_o       = rdata1.bpu;
    end
    if (issue_en) begin
      ibus.inst2_o      = rdata2.inst;
      ibus.inst2_addr_o = rdata2.addr;
      ibus.bpu2_o       = rdata2.bpu;
    end
  end

  assign ibus.issue_en_o        = issue_en;
  assign ibus.is_in_delayslot_o = delayslot;
  assign ibus.buffer_full_o     = full;
  assign ibus.count_o           = count;

endmodule

// File: tb/tb_inst_issue_buffer.sv
// Self-checking bench for inst_issue_buffer: a queue scoreboard models the
// buffer contents, plus a table of vectors with hand-derived occupancy and
// delay-slot expectations and hand-written corner sequences.
module tb_inst_issue_buffer;
  import inst_issue_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_issue_buffer_if bus ();

  inst_issue_buffer dut (
    .clk  (clk),
    .rst  (rst),
    .ibus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  ibuf_entry_t sb[$];
  logic        m_ds;
  logic [31:0] pc_next;
  int          seq;

  typedef struct {
    bit v1, v2, iss, mode, nd, fl;
    int exp_count;
    bit exp_ds;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ibuf_entry_t make_entry(input logic [31:0] pc, input int s);
    ibuf_entry_t e;
    logic [15:0] s16;
    s16    = s[15:0];
    e.inst = 32'h2400_0000 | (32'(s16[7:0]) << 16) | 32'(s16);
    e.addr = pc;
    e.bpu  = {s16[0], pc ^ 32'h0000_1000};
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    ibuf_entry_t e1, e2;
    e1 = (sb.size() >= 1) ? sb[0] : '0;
    e2 = (sb.size() >= 2) ? sb[1] : '0;
    check({tag, ".count"},    bus.count_o,           sb.size());
    check({tag, ".issue_en"}, bus.issue_en_o,        sb.size() >= 2);
    check({tag, ".full"},     bus.buffer_full_o,     sb.size() >= 30);
    check({tag, ".ds"},       bus.is_in_delayslot_o, m_ds);
    check({tag, ".inst1"},    bus.inst1_o,           e1.inst);
    check({tag, ".addr1"},    bus.inst1_addr_o,      e1.addr);
    check({tag, ".bpu1"},     bus.bpu1_o,            e1.bpu);
    check({tag, ".inst2"},    bus.inst2_o,           e2.inst);
    check({tag, ".addr2"},    bus.inst2_addr_o,      e2.addr);
    check({tag, ".bpu2"},     bus.bpu2_o,            e2.bpu);
  endtask

  // One clock: drive stimulus, advance the scoreboard per the buffer rules,
  // then compare all outputs 1 time unit after the edge.
  task automatic step(input string tag, input bit v1, input bit v2, input bit iss,
                      input bit mode, input bit nd, input bit fl);
    ibuf_entry_t f1, f2;
    int          npop;
    bit          full;
    f1 = make_entry(pc_next, seq);
    f2 = make_entry(pc_next + 32'd4, seq + 1);
    bus.fetch_valid1_i       = v1;
    bus.fetch_valid2_i       = v2;
    bus.fetch_inst1_i        = f1.inst;
    bus.fetch_addr1_i        = f1.addr;
    bus.fetch_bpu1_i         = f1.bpu;
    bus.fetch_inst2_i        = f2.inst;
    bus.fetch_addr2_i        = f2.addr;
    bus.fetch_bpu2_i         = f2.bpu;
    bus.issued_i             = iss;
    bus.issue_mode_i         = mode;
    bus.ninst_in_delayslot_i = nd;
    bus.flush_i              = fl;
    @(posedge clk);
    if (fl) begin
      sb.delete();
      m_ds = 1'b0;
    end else begin
      full = (sb.size() >= 30);
      npop = (iss && sb.size() >= 2) ? (mode ? 2 : 1) : 0;
      for (int i = 0; i < npop; i++) void'(sb.pop_front());
      if (npop == 1) m_ds = nd;
      else if (npop == 2) m_ds = 1'b0;
      if (v1 && !full) begin
        sb.push_back(f1);
        pc_next += 32'd4;
        seq++;
        if (v2) begin
          sb.push_back(f2);
          pc_next += 32'd4;
          seq++;
        end
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] base;
    m_ds    = 1'b0;
    pc_next = 32'hBFC0_0000;
    seq     = 1;

    // Reset with flush and fetch active: reset must win and nothing enters.
    rst                      = 1'b1;
    bus.flush_i              = 1'b1;
    bus.fetch_valid1_i       = 1'b1;
    bus.fetch_valid2_i       = 1'b1;
    bus.fetch_inst1_i        = 32'hDEAD_BEEF;
    bus.fetch_inst2_i        = 32'hDEAD_BEEF;
    bus.fetch_addr1_i        = 32'h1;
    bus.fetch_addr2_i        = 32'h2;
    bus.fetch_bpu1_i         = '1;
    bus.fetch_bpu2_i         = '1;
    bus.issued_i             = 1'b1;
    bus.issue_mode_i         = 1'b1;
    bus.ninst_in_delayslot_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst                = 1'b0;
    bus.flush_i        = 1'b0;
    bus.fetch_valid1_i = 1'b0;
    bus.fetch_valid2_i = 1'b0;
    bus.issued_i       = 1'b0;
    check_outputs("reset");

    // First dual push becomes visible the following cycle.
    step("push2", 1, 1, 0, 0, 0, 0);
    check("push2.count_c",    bus.count_o,      6'd2);
    check("push2.issue_en_c", bus.issue_en_o,   1'b1);
    check("push2.inst1_c",    bus.inst1_o,      32'h2401_0001);
    check("push2.addr1_c",    bus.inst1_addr_o, 32'hBFC0_0000);
    check("push2.inst2_c",    bus.inst2_o,      32'h2402_0002);
    check("push2.addr2_c",    bus.inst2_addr_o, 32'hBFC0_0004);
    step("drain0", 0, 0, 1, 1, 0, 0);

    // Table: single pushes, ignored valid2, pops gated by count < 2,
    // delay-slot set/hold/clear.
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 1, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 2, 0};
    vecs[2]  = '{0, 1, 1, 0, 1, 0, 1, 1};
    vecs[3]  = '{1, 1, 0, 0, 0, 0, 3, 1};
    vecs[4]  = '{0, 0, 1, 1, 0, 0, 1, 0};
    vecs[5]  = '{0, 0, 1, 1, 0, 0, 1, 0};
    vecs[6]  = '{1, 0, 1, 0, 1, 0, 2, 0};
    vecs[7]  = '{1, 1, 1, 0, 1, 0, 3, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 3, 1};
    vecs[9]  = '{0, 0, 1, 1, 0, 0, 1, 0};
    vecs[10] = '{1, 1, 1, 0, 1, 0, 3, 0};
    vecs[11] = '{0, 0, 1, 0, 0, 0, 2, 0};
    vecs[12] = '{0, 0, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      step($sformatf("vec%0d", i), vecs[i].v1, vecs[i].v2, vecs[i].iss,
           vecs[i].mode, vecs[i].nd, vecs[i].fl);
      check($sformatf("vec%0d.count_c", i), bus.count_o, vecs[i].exp_count);
      check($sformatf("vec%0d.ds_c", i), bus.is_in_delayslot_o, vecs[i].exp_ds);
    end

    // Fill to the full threshold; further pushes are refused.
    for (int i = 0; i < 15; i++) step("fill", 1, 1, 0, 0, 0, 0);
    check("fill.count_c", bus.count_o,       6'd30);
    check("fill.full_c",  bus.buffer_full_o, 1'b1);
    step("full_push", 1, 1, 0, 0, 0, 0);
    check("full_push.count_c", bus.count_o, 6'd30);
    step("full_pop", 1, 1, 1, 1, 0, 0);
    check("full_pop.count_c", bus.count_o,       6'd28);
    check("full_pop.full_c",  bus.buffer_full_o, 1'b0);
    for (int i = 0; i < 14; i++) step("drain1", 0, 0, 1, 1, 0, 0);

    // Steady dual push/pop across pointer wrap.
    step("wrap_pre", 1, 1, 0, 0, 0, 0);
    step("wrap_pre", 1, 1, 0, 0, 0, 0);
    base = sb[0].addr;
    for (int i = 0; i < 40; i++) begin
      step("wrap", 1, 1, 1, 1, 0, 0);
      check("wrap.pc_step", bus.inst1_addr_o, base + 32'(8 * (i + 1)));
      check("wrap.count_c", bus.count_o, 6'd4);
    end

    // Delay slot: single pop of a branch, then a dual pop clears it.
    step("ds_single", 0, 0, 1, 0, 1, 0);
    check("ds_single.ds_c", bus.is_in_delayslot_o, 1'b1);
    step("ds_dual", 0, 0, 1, 1, 0, 0);
    check("ds_dual.ds_c", bus.is_in_delayslot_o, 1'b0);
    step("flush_only", 0, 0, 0, 0, 0, 1);

    // Flush beats a same-cycle dual push and dual pop at count 6.
    for (int i = 0; i < 3; i++) step("pre_flush", 1, 1, 0, 0, 0, 0);
    step("pre_flush_ds", 1, 0, 1, 0, 1, 0);
    check("pre_flush.count_c", bus.count_o,           6'd6);
    check("pre_flush.ds_c",    bus.is_in_delayslot_o, 1'b1);
    step("flush", 1, 1, 1, 1, 0, 1);
    check("flush.count_c",    bus.count_o,           6'd0);
    check("flush.issue_en_c", bus.issue_en_o,        1'b0);
    check("flush.ds_c",       bus.is_in_delayslot_o, 1'b0);
    step("post_flush", 1, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
